sync_lut_ram: RTL and testbench
===============================

Name: sync_lut_ram

Overview:
Parametrised synchronous lookup memory: WD-bit words, DP deep, one write port and one registered read port.
- Self-initialises every location to INIT_BASE+index after reset or on request, using an internal walk FSM.
- Serves as the general table/constant store for datapath blocks that need runtime-patchable lookup values with a read-valid handshake.

Parameters:
WD, 8, data word width in bits
DP, 16, number of words
ADDR_WD, clogb2(DP), address width; derived, not overridden
INIT_BASE, 8'hA0, init pattern: location i loads (INIT_BASE + i) truncated to WD LSBs

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_rst  input  1  reset; asynchronous, active-high
i_init  input  1  request re-initialisation; sampled only in READY
i_wr_en  input  1  write strobe
i_wr_addr  input  ADDR_WD  write address
i_wr_data  input  WD  write data
i_rd_en  input  1  read strobe
i_rd_addr  input  ADDR_WD  read address
o_rd_data  output  WD  registered read data
o_rd_valid  output  1  one-cycle pulse; o_rd_data is valid
o_ready  output  1  high when in READY; accesses are accepted only then
o_addr_err  output  1  one-cycle pulse on an access with address >= DP

Behaviour:
- Reset (async assert): o_rd_data=0 (Z when the optional feature is on), o_rd_valid=0, o_ready=0, o_addr_err=0, state=INIT, init counter=0. Memory contents are not reset.
- FSM states: INIT, READY.
- INIT:
  - Each edge writes mem[cnt] = (INIT_BASE+cnt)[WD-1:0] and increments cnt.
  - On the edge that writes cnt=DP-1, go to READY; o_ready goes high after that edge.
  - Total time from reset release to o_ready high: exactly DP edges.
- INIT ignores i_wr_en, i_rd_en and i_init. o_rd_valid and o_addr_err stay 0.
- READY, i_init=1: go to INIT on the next edge with cnt=0 and o_ready low. A read or write presented on that same edge is still performed; a write is later overwritten by the walk.
- Read, READY and i_rd_en=1:
  - 1-cycle latency: after the edge, o_rd_data=mem[i_rd_addr] and o_rd_valid=1 for one cycle.
  - Back-to-back reads give one result per cycle.
- Write, READY and i_wr_en=1: mem[i_wr_addr]=i_wr_data at the edge.
- Same-address read and write on one edge: read-first. The read returns the old data; the new data is visible from the next read.
- Address range: only reachable when DP is not a power of two.
  - Read with address >= DP: o_rd_data=0, o_rd_valid=1, o_addr_err=1.
  - Write with address >= DP: write dropped, o_addr_err=1.
  - Both out of range on one edge: a single o_addr_err pulse.
- o_rd_data with o_rd_valid=0: holds its last value (feature off).
- Reset asserted mid-INIT or mid-read: outputs return to reset values immediately; the walk restarts from 0 after release.
- Arithmetic: INIT_BASE+cnt is computed in 32 bits, then truncated to WD bits. Wrap-around is therefore allowed, e.g. WD=8, INIT_BASE=8'hF8 gives location 8 = 8'h00.

Optional Feature:
Macro SYNC_LUT_TRISTATE_OUT_EN.
- Defined: o_rd_data is driven only while o_rd_valid=1, and is high-Z otherwise, including during reset. This allows several instances to share one read bus.
- Undefined: o_rd_data is always driven, holds its last value, and resets to 0.

Decomposition:
- Shared package sync_lut_pkg:
  - clogb2 constant function
  - state encodings ST_INIT=1'b0, ST_READY=1'b1
- One sub-module, sync_lut_init_seq: INIT/READY FSM plus init counter. Outputs are init write enable, init address, init data and ready.
- The top level muxes init vs user writes and holds the array and the read register.

Test Plan:
- WD=8, DP=16, reset released → o_ready low for 16 edges then high; read addr 5 → o_rd_data=8'hA5 with o_rd_valid high for exactly 1 cycle; read addr 15 → 8'hAF.
- Write addr 3=8'h5C, then read 3 → 8'h5C. Same edge write addr 7=8'h11 and read 7 → 8'hA7; next read 7 → 8'h11.
- After the writes above, pulse i_init → o_ready low for 16 edges; then read 3 → 8'hA3 and read 7 → 8'hA7.
- Assert i_rst after 8 INIT edges → all outputs at reset values immediately; after release o_ready rises only after a full 16 edges.
- DP=12 instance: read addr 13 → o_rd_data=0, o_rd_valid=1, o_addr_err=1. Write addr 14=8'hFF → o_addr_err=1, and a read of every address 0–11 still matches the init pattern.
- Reads and writes issued during INIT → no o_rd_valid, contents unchanged. With SYNC_LUT_TRISTATE_OUT_EN defined, o_rd_data='z whenever o_rd_valid=0.

Source files
------------

// File: rtl/sync_lut_ram_pkg.sv
// sync_lut_pkg: shared state encoding and address-width helper for the lookup RAM
package sync_lut_pkg;
  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/sync_lut_ram_if.sv
// sync_lut_ram_if: access bus of the lookup RAM (init request, write port, read port, status)
interface sync_lut_ram_if #(parameter int WD = 8, parameter int AW = 4);
  logic init;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [WD-1:0] wr_data;
  logic rd_en;
  logic [AW-1:0] rd_addr;
  logic [WD-1:0] rd_data;
  logic rd_valid;
  logic ready;
  logic addr_err;
  modport master (output init, wr_en, wr_addr, wr_data, rd_en, rd_addr,
                  input rd_data, rd_valid, ready, addr_err);
  modport slave (input init, wr_en, wr_addr, wr_data, rd_en, rd_addr,
                 output rd_data, rd_valid, ready, addr_err);
endinterface

// File: rtl/sync_lut_init_seq.sv
// sync_lut_init_seq: INIT/READY walk that loads INIT_BASE+index into every location
module sync_lut_init_seq
  import sync_lut_pkg::*;
#(
  parameter int WD = 8,
  parameter int DP = 16,
  parameter int AW = 4,
  parameter logic [31:0] INIT_BASE = 32'hA0
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  output logic init_we,
  output logic [AW-1:0] init_addr,
  output logic [WD-1:0] init_data,
  output logic ready
);
  state_t state;
  logic [AW-1:0] cnt;
  logic last;
  assign last = cnt == AW'(DP - 1);
  // walk one location per edge in INIT; a re-init request is honoured only from READY
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_INIT;
      cnt <= '0;
    end else if (state == ST_INIT) begin
      cnt <= last ? '0 : cnt + 1'b1;
      state <= last ? ST_READY : ST_INIT;
    end else if (init) begin
      state <= ST_INIT;
      cnt <= '0;
    end
  assign init_we = state == ST_INIT;
  assign ready = state == ST_READY;
  assign init_addr = cnt;
  assign init_data = WD'(INIT_BASE + 32'(cnt));
endmodule

// File: rtl/sync_lut_ram.sv
// sync_lut_ram: self-initialising lookup RAM with read-first registered read port.
// Define SYNC_LUT_TRISTATE_OUT_EN to float rd_data whenever rd_valid is low.
module sync_lut_ram
  import sync_lut_pkg::*;
#(
  parameter int WD = 8,
  parameter int DP = 16,
  parameter logic [31:0] INIT_BASE = 32'hA0
) (
  input logic clk,
  input logic rst,
  sync_lut_ram_if.slave bus
);
  localparam int ADDR_WD = clogb2(DP);
  logic init_we, ready, valid, err;
  logic [ADDR_WD-1:0] init_addr;
  logic [WD-1:0] init_data, rd_q;
  logic [WD-1:0] mem [DP];
  logic rd_ok, wr_ok, rd_oob, wr_oob;
  sync_lut_init_seq #(.WD(WD), .DP(DP), .AW(ADDR_WD), .INIT_BASE(INIT_BASE)) u_seq (
    .clk(clk), .rst(rst), .init(bus.init), .init_we(init_we),
    .init_addr(init_addr), .init_data(init_data), .ready(ready)
  );
  assign rd_ok = ready & bus.rd_en;
  assign wr_ok = ready & bus.wr_en;
  assign rd_oob = int'(bus.rd_addr) >= DP;
  assign wr_oob = int'(bus.wr_addr) >= DP;
  // array is not reset; the walk owns it in INIT, user writes land only in READY
  always_ff @(posedge clk)
    if (init_we) mem[init_addr] <= init_data;
    else if (wr_ok && !wr_oob) mem[bus.wr_addr] <= bus.wr_data;
  // registered read: old contents are sampled on a same-address write edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q <= '0;
      valid <= 1'b0;
      err <= 1'b0;
    end else begin
      valid <= rd_ok;
      err <= (rd_ok & rd_oob) | (wr_ok & wr_oob);
      if (rd_ok) rd_q <= rd_oob ? '0 : mem[bus.rd_addr];
    end
`ifdef SYNC_LUT_TRISTATE_OUT_EN
  assign bus.rd_data = valid ? rd_q : 'z;
`else
  assign bus.rd_data = rd_q;
`endif
  assign bus.rd_valid = valid;
  assign bus.ready = ready;
  assign bus.addr_err = err;
endmodule

// File: tb/tb_sync_lut_ram.sv
// tb_sync_lut_ram: scoreboard bench for a DP=16 and a DP=12 (wrapping base) instance
module tb_sync_lut_ram;
  import sync_lut_pkg::*;
  typedef struct packed {logic vld; logic err; logic [7:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[2][$];
  logic [7:0] ref_m [2][16];
  logic [7:0] hold [2];
  bit rdy [2];
  int walk [2];
  int dp [2] = '{16, 12};
  logic [31:0] base [2] = '{32'hA0, 32'hF8};
  string nm [2] = '{"a", "b"};

  sync_lut_ram_if #(.WD(8), .AW(clogb2(16))) ia ();
  sync_lut_ram_if #(.WD(8), .AW(clogb2(12))) ib ();
  sync_lut_ram #(.WD(8), .DP(16), .INIT_BASE(32'hA0)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  sync_lut_ram #(.WD(8), .DP(12), .INIT_BASE(32'hF8)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic fill(input int w);
    for (int i = 0; i < dp[w]; i++) ref_m[w][i] = 8'(base[w] + 32'(i));
  endtask

  task automatic idle();
    ia.init = 0; ia.wr_en = 0; ia.wr_addr = '0; ia.wr_data = '0; ia.rd_en = 0; ia.rd_addr = '0;
    ib.init = 0; ib.wr_en = 0; ib.wr_addr = '0; ib.wr_data = '0; ib.rd_en = 0; ib.rd_addr = '0;
  endtask

  task automatic set(input int w, input bit rd, input int ra, input bit wr, input int wa,
                     input logic [7:0] wd, input bit ini);
    exp_t e;
    if (w == 0) begin
      ia.rd_en = rd; ia.rd_addr = 4'(ra); ia.wr_en = wr; ia.wr_addr = 4'(wa); ia.wr_data = wd; ia.init = ini;
    end else begin
      ib.rd_en = rd; ib.rd_addr = 4'(ra); ib.wr_en = wr; ib.wr_addr = 4'(wa); ib.wr_data = wd; ib.init = ini;
    end
    if (rdy[w]) begin
      if (rd) begin
        e.vld = 1'b1;
        e.err = (ra >= dp[w]) || (wr && wa >= dp[w]);
        e.data = (ra >= dp[w]) ? 8'h00 : ref_m[w][ra];
        q[w].push_back(e);
      end else if (wr && wa >= dp[w]) begin
        e.vld = 1'b0; e.err = 1'b1; e.data = 8'h00;
        q[w].push_back(e);
      end
      if (wr && wa < dp[w]) ref_m[w][wa] = wd;
      if (ini) begin
        rdy[w] = 0;
        walk[w] = dp[w] + 1;
        fill(w);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int w = 0; w < 2; w++)
      if (!rdy[w]) begin
        walk[w]--;
        if (walk[w] == 0) rdy[w] = 1;
      end
    #1;
    idle();
    chk("ready_a", ia.ready, rdy[0]);
    chk("ready_b", ib.ready, rdy[1]);
  endtask

  task automatic chk_rst();
    chk("rst_valid_a", ia.rd_valid, 0);
    chk("rst_ready_a", ia.ready, 0);
    chk("rst_err_a", ia.addr_err, 0);
    chk("rst_valid_b", ib.rd_valid, 0);
    chk("rst_ready_b", ib.ready, 0);
    chk("rst_err_b", ib.addr_err, 0);
`ifdef SYNC_LUT_TRISTATE_OUT_EN
    chk("rst_data_a", ia.rd_data, 8'hzz);
    chk("rst_data_b", ib.rd_data, 8'hzz);
`else
    chk("rst_data_a", ia.rd_data, 8'h00);
    chk("rst_data_b", ib.rd_data, 8'h00);
`endif
  endtask

  task automatic reset_cycle();
    rst = 1;
    #1;
    chk_rst();
    for (int w = 0; w < 2; w++) begin
      q[w].delete();
      hold[w] = 8'h00;
      rdy[w] = 0;
      walk[w] = dp[w];
      fill(w);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic chk_idle(input int w, input logic [7:0] d);
`ifdef SYNC_LUT_TRISTATE_OUT_EN
    chk({"float_", nm[w]}, d, 8'hzz);
`else
    chk({"hold_", nm[w]}, d, hold[w]);
`endif
  endtask

  task automatic mon(input int w, input logic v, input logic er, input logic [7:0] d);
    exp_t e;
    if (v || er) begin
      if (q[w].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexp_%s: got valid=%b err=%b data=%h expected no output", nm[w], v, er, d);
      end else begin
        e = q[w].pop_front();
        chk({"valid_", nm[w]}, v, e.vld);
        chk({"err_", nm[w]}, er, e.err);
        if (e.vld) begin
          chk({"data_", nm[w]}, d, e.data);
          hold[w] = e.data;
        end else chk_idle(w, d);
      end
    end else chk_idle(w, d);
  endtask

  // monitor: pop and compare whenever either instance presents a result
  always @(negedge clk)
    if (!rst) begin
      mon(0, ia.rd_valid, ia.addr_err, ia.rd_data);
      mon(1, ib.rd_valid, ib.addr_err, ib.rd_data);
    end

  initial begin
    idle();
    hold = '{8'h00, 8'h00};
    rdy = '{0, 0};
    walk = '{16, 12};
    fill(0);
    fill(1);
    repeat (2) @(posedge clk);
    #1;
    chk_rst();
    rst = 0;
    repeat (16) tick();
    set(0, 1, 5, 0, 0, 8'h00, 0); tick();
    set(0, 1, 15, 0, 0, 8'h00, 0); tick();
    set(0, 0, 0, 1, 3, 8'h5C, 0); tick();
    set(0, 1, 3, 0, 0, 8'h00, 0); tick();
    set(0, 1, 7, 1, 7, 8'h11, 0); tick();
    set(0, 1, 7, 0, 0, 8'h00, 0); tick();
    set(0, 1, 3, 1, 3, 8'h77, 1); tick();
    repeat (16) tick();
    set(0, 1, 3, 0, 0, 8'h00, 0); tick();
    set(0, 1, 7, 0, 0, 8'h00, 0); tick();
    set(1, 1, 13, 0, 0, 8'h00, 0); tick();
    set(1, 0, 0, 1, 14, 8'hFF, 0); tick();
    set(1, 1, 13, 1, 12, 8'h55, 0); tick();
    for (int i = 0; i < 12; i++) begin
      set(1, 1, i, 0, 0, 8'h00, 0);
      tick();
    end
    set(0, 1, 2, 0, 0, 8'h00, 0); tick();
    reset_cycle();
    repeat (8) tick();
    reset_cycle();
    repeat (5) begin
      set(0, 1'($urandom), int'($urandom % 16), 1'($urandom), int'($urandom % 16), 8'($urandom), 1'($urandom));
      set(1, 1'($urandom), int'($urandom % 16), 1'($urandom), int'($urandom % 16), 8'($urandom), 1'($urandom));
      tick();
    end
    repeat (11) tick();
    for (int i = 0; i < 16; i++) begin
      set(0, 1, i, 0, 0, 8'h00, 0);
      if (i < 12) set(1, 1, i, 0, 0, 8'h00, 0);
      tick();
    end
    repeat (400) begin
      set(0, 1'($urandom), int'($urandom % 16), 1'($urandom), int'($urandom % 16), 8'($urandom),
          ($urandom % 64) == 0);
      set(1, 1'($urandom), int'($urandom % 16), 1'($urandom), int'($urandom % 16), 8'($urandom),
          ($urandom % 64) == 0);
      tick();
    end
    repeat (3) tick();
    chk("pending_a", q[0].size(), 0);
    chk("pending_b", q[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
